// File: rtl/ras_call_return_detect_pkg.sv
// rtl/ras_call_return_detect_pkg.sv - RISC-V opcode constants, link-register test and RAS op type
package ras_call_return_detect_pkg;

  // RV32 major opcodes that matter to return-address prediction
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Per-instruction RAS action: push a return address, pop one, and whether
  // the instruction is a speculative branch that needs a RAS checkpoint.
  typedef struct packed {
    logic push;
    logic pop;
    logic spec;
  } ras_op_t;

  // x1 (ra) and x5 (t0) are the architectural link registers
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_call_return_detect_classify.sv
// rtl/ras_call_return_detect_classify.sv - combinational call/return/coroutine classifier
module ras_instr_classify
  import ras_call_return_detect_pkg::*;
(
  input  logic [31:0] instr_i,
  output ras_op_t     op_o
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_instr_bits;

  assign opcode   = instr_i[6:0];
  assign rd       = instr_i[11:7];
  assign rs1      = instr_i[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // Immediate and funct3 fields play no part in the hint table
  assign unused_instr_bits = ^{instr_i[31:20], instr_i[14:12]};

  // Hint-table decode: a JALR popping and pushing the same link register is a
  // plain call (push only); different link registers form a coroutine swap.
  always_comb begin
    op_o = '0;
    unique case (opcode)
      OPC_JAL: begin
        op_o.push = rd_link;
      end
      OPC_JALR: begin
        op_o.spec = 1'b1;
        op_o.push = rd_link;
        op_o.pop  = rs1_link & (~rd_link | (rd != rs1));
      end
      OPC_BRANCH: begin
        op_o.spec = 1'b1;
      end
      default: begin
        op_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ras_call_return_detect.sv
// rtl/ras_call_return_detect.sv - RAS strobe register stage, checkpoint tracking and fetch back-pressure
module ras_call_return_detect
  import ras_call_return_detect_pkg::*;
#(
  parameter int MAX_IDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_flush,
  input  logic        early_branch_flush,
  input  logic        branch_retire_in,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [31:0] ras_new_addr,
  output logic        ras_branch_fetched,
  output logic        ras_branch_retired
);

  localparam int CW = $clog2(MAX_IDS + 1);

  ras_op_t       op;
  logic          flush;
  logic          accept;
  logic          spec_accept;
  logic          retire_ok;

  logic [CW-1:0] count_q, count_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          fetched_q, fetched_d;
  logic          retired_q, retired_d;
  logic [31:0]   addr_q, addr_d;

  ras_instr_classify u_classify (
    .instr_i (fetch_instr),
    .op_o    (op)
  );

  assign flush       = fetch_flush | early_branch_flush;
  assign fetch_ready = (count_q < CW'(MAX_IDS)) & ~fetch_flush;
  assign accept      = fetch_valid & fetch_ready;
  assign spec_accept = accept & op.spec;
  assign retire_ok   = branch_retire_in & (count_q != '0);

  // Outstanding checkpoints: a flush discards all of them and any same-cycle events
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (spec_accept && !retire_ok) begin
      count_d = count_q + CW'(1);
    end else if (retire_ok && !spec_accept) begin
      count_d = count_q - CW'(1);
    end
  end

  // Next-state strobes; the return address only moves when a push is issued
  always_comb begin
    push_d    = accept & op.push & ~flush;
    pop_d     = accept & op.pop  & ~flush;
    fetched_d = spec_accept & ~flush;
    retired_d = retire_ok & ~flush;
    addr_d    = addr_q;
    if (push_d) begin
      addr_d = fetch_pc + 32'd4;
    end
  end

  // Single registered stage toward the RAS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      fetched_q <= 1'b0;
      retired_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      count_q   <= count_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      fetched_q <= fetched_d;
      retired_q <= retired_d;
      addr_q    <= addr_d;
    end
  end

  // A flush arriving one cycle after the accept kills that accept's strobes
  assign ras_push           = push_q    & ~flush;
  assign ras_pop            = pop_q     & ~flush;
  assign ras_branch_fetched = fetched_q & ~flush;
  assign ras_branch_retired = retired_q;
  assign ras_new_addr       = addr_q;

endmodule

// File: tb/tb_ras_call_return_detect.sv
// tb/tb_ras_call_return_detect.sv - scoreboard bench for ras_call_return_detect
module tb_ras_call_return_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic        fetch_flush = 1'b0;
  logic        early_branch_flush = 1'b0;
  logic        branch_retire_in = 1'b0;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_addr;
  logic        ras_branch_fetched;
  logic        ras_branch_retired;

  localparam logic [31:0] I_JAL_X1    = 32'h000000EF;
  localparam logic [31:0] I_RET       = 32'h00008067;
  localparam logic [31:0] I_JALR_X5X1 = 32'h000082E7;
  localparam logic [31:0] I_JALR_X1X1 = 32'h000080E7;
  localparam logic [31:0] I_BEQ       = 32'h00000063;
  localparam logic [31:0] I_NOP       = 32'h00000013;

  typedef struct {
    logic        push;
    logic        pop;
    logic        bf;
    logic        br;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  ras_call_return_detect #(.MAX_IDS(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .fetch_pc           (fetch_pc),
    .fetch_instr        (fetch_instr),
    .fetch_flush        (fetch_flush),
    .early_branch_flush (early_branch_flush),
    .branch_retire_in   (branch_retire_in),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_new_addr       (ras_new_addr),
    .ras_branch_fetched (ras_branch_fetched),
    .ras_branch_retired (ras_branch_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobes for the previous cycle's vector are visible mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("push", {31'd0, ras_push}, {31'd0, e.push});
      check("pop", {31'd0, ras_pop}, {31'd0, e.pop});
      check("branch_fetched", {31'd0, ras_branch_fetched}, {31'd0, e.bf});
      check("branch_retired", {31'd0, ras_branch_retired}, {31'd0, e.br});
      if (e.push) check("new_addr", ras_new_addr, e.addr);
    end
  end

  // One cycle of stimulus; expectations describe the strobes seen in the next cycle
  task automatic vec(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ff, input logic ef, input logic rt, input logic rdy,
                     input logic p, input logic po, input logic bf, input logic br,
                     input logic [31:0] a);
    exp_t e;
    fetch_valid        = v;
    fetch_pc           = pc;
    fetch_instr        = ins;
    fetch_flush        = ff;
    early_branch_flush = ef;
    branch_retire_in   = rt;
    #1;
    check("fetch_ready", {31'd0, fetch_ready}, {31'd0, rdy});
    @(posedge clk);
    e.push = p; e.pop = po; e.bf = bf; e.br = br; e.addr = a;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_ready", {31'd0, fetch_ready}, 32'd1);
    check("reset_push", {31'd0, ras_push}, 32'd0);
    check("reset_pop", {31'd0, ras_pop}, 32'd0);
    check("reset_addr", ras_new_addr, 32'd0);
    check("reset_bf", {31'd0, ras_branch_fetched}, 32'd0);
    check("reset_br", {31'd0, ras_branch_retired}, 32'd0);
    @(posedge clk);
    #1;

    //   v  pc            instr        ff ef rt rdy  p  po bf br addr
    vec(1, 32'h1000, I_JAL_X1,    0, 0, 0, 1,   1, 0, 0, 0, 32'h1004);
    vec(1, 32'h1010, I_RET,       0, 0, 0, 1,   0, 1, 1, 0, 32'h1004);
    vec(1, 32'h2000, I_JALR_X5X1, 0, 0, 0, 1,   1, 1, 1, 0, 32'h2004);
    vec(1, 32'h3000, I_JALR_X1X1, 0, 0, 0, 1,   1, 0, 1, 0, 32'h3004);
    vec(1, 32'h3100, I_BEQ,       0, 0, 1, 1,   0, 0, 1, 1, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 1, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 1, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 1, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 0, 32'h3004);
    for (int i = 0; i < 8; i++) begin
      vec(1, 32'h4000 + 32'(i * 4), I_BEQ, 0, 0, 0, 1, 0, 0, 1, 0, 32'h3004);
    end
    vec(1, 32'h4020, I_BEQ,       0, 0, 0, 0,   0, 0, 0, 0, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 0,   0, 0, 0, 1, 32'h3004);
    vec(0, 32'h0,    I_NOP,       0, 0, 0, 1,   0, 0, 0, 0, 32'h3004);
    vec(1, 32'h5000, I_JAL_X1,    0, 0, 0, 1,   0, 0, 0, 0, 32'h5004);
    vec(0, 32'h0,    I_NOP,       1, 0, 0, 0,   0, 0, 0, 0, 32'h5004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 0, 32'h5004);
    vec(1, 32'h5100, I_BEQ,       0, 0, 0, 1,   0, 0, 0, 0, 32'h5004);
    vec(0, 32'h0,    I_NOP,       0, 1, 0, 1,   0, 0, 0, 0, 32'h5004);
    vec(0, 32'h0,    I_NOP,       0, 0, 1, 1,   0, 0, 0, 0, 32'h5004);
    vec(1, 32'hFFFFFFFC, I_JAL_X1, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0);
    vec(0, 32'h0,    I_NOP,       0, 0, 0, 1,   0, 0, 0, 0, 32'h0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset between clock edges
    fetch_valid = 1'b1;
    fetch_pc    = 32'h6000;
    fetch_instr = I_JAL_X1;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    check("pre_rst_push", {31'd0, ras_push}, 32'd1);
    check("pre_rst_addr", ras_new_addr, 32'h6004);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_push", {31'd0, ras_push}, 32'd0);
    check("async_rst_addr", ras_new_addr, 32'd0);
    check("async_rst_ready", {31'd0, fetch_ready}, 32'd1);

    // Instruction offered while reset is held produces nothing
    fetch_valid = 1'b1;
    fetch_pc    = 32'h7000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_inflight_push", {31'd0, ras_push}, 32'd0);
    check("rst_inflight_addr", ras_new_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
